// File: rtl/demux_pkg.sv
// Shared constants and FSM encoding for the 1-to-8 demux/deserializer.
package demux_pkg;

    localparam int LANES = 8;
    localparam int SEL_W = $clog2(LANES);

    // FSM encoding kept as plain constants so older code can compare against raw bits.
    typedef logic [0:0] state_t;
    localparam state_t IDLE    = 1'b0;
    localparam state_t COLLECT = 1'b1;

endpackage

// File: rtl/demux_lane_cnt.sv
// Lane counter: selects the shadow lane for the next accepted auto-mode bit.
// Clear wins over load-to-1, which wins over increment; the lane-7 increment
// wraps to 0 by plain modulo arithmetic.
module demux_lane_cnt
    import demux_pkg::*;
(
    input  logic             clk,
    input  logic             clr,
    input  logic             load1,
    input  logic             en,
    output logic [SEL_W-1:0] cnt,
    output logic             last
);

    // Counter register with clear/load/enable priority.
    always_ff @(posedge clk) begin
        if (clr) begin
            cnt <= '0;
        end else if (load1) begin
            cnt <= SEL_W'(1);
        end else if (en) begin
            cnt <= cnt + SEL_W'(1);
        end
    end

    assign last = (cnt == SEL_W'(LANES - 1));

endmodule

// File: rtl/demux1_8_deser.sv
// Sequential 1-to-8 demultiplexer / deserializer.
// Auto mode gathers eight bits in a shadow register and publishes them to
// q0..q7 in one cycle with a frame_done strobe; manual mode writes each
// accepted bit straight into the lane chosen by sel_ext.
module demux1_8_deser
    import demux_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             din,
    input  logic             din_valid,
    input  logic             sof,
    input  logic             auto_en,
    input  logic [SEL_W-1:0] sel_ext,
    output logic             q0,
    output logic             q1,
    output logic             q2,
    output logic             q3,
    output logic             q4,
    output logic             q5,
    output logic             q6,
    output logic             q7,
    output logic [SEL_W-1:0] sel_cur,
    output logic             busy,
    output logic             frame_done
);

    state_t             state;
    logic [LANES-2:0]   shadow;
    logic [LANES-1:0]   lane_q;
    logic               cnt_clr;
    logic               cnt_load1;
    logic               cnt_en;
    logic               cnt_last;
    logic               accept_auto;

    assign accept_auto = auto_en & din_valid;
    assign cnt_clr     = rst | ~auto_en;
    assign cnt_load1   = accept_auto & sof;
    assign cnt_en      = accept_auto & ~sof & (state == COLLECT);

    demux_lane_cnt u_lane_cnt (
        .clk   (clk),
        .clr   (cnt_clr),
        .load1 (cnt_load1),
        .en    (cnt_en),
        .cnt   (sel_cur),
        .last  (cnt_last)
    );

    // FSM, shadow capture, atomic frame publish and manual lane writes.
    // The lane-7 bit goes straight to q7 so shadow only needs lanes 0..6.
    // When auto_en drops during COLLECT the abort takes precedence and q is
    // left untouched for that cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            shadow     <= '0;
            lane_q     <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (!auto_en) begin
                state <= IDLE;
                if (din_valid && (state == IDLE)) begin
                    lane_q[sel_ext] <= din;
                end
            end else if (din_valid) begin
                if (sof) begin
                    shadow[0] <= din;
                    state     <= COLLECT;
                end else if (state == COLLECT) begin
                    if (cnt_last) begin
                        lane_q     <= {din, shadow};
                        frame_done <= 1'b1;
                        state      <= IDLE;
                    end else begin
                        shadow[sel_cur] <= din;
                    end
                end
            end
        end
    end

    assign busy = (state == COLLECT);

    assign q0 = lane_q[0];
    assign q1 = lane_q[1];
    assign q2 = lane_q[2];
    assign q3 = lane_q[3];
    assign q4 = lane_q[4];
    assign q5 = lane_q[5];
    assign q6 = lane_q[6];
    assign q7 = lane_q[7];

endmodule

// File: tb/tb_demux1_8_deser.sv
// Directed self-checking bench for demux1_8_deser.
module tb_demux1_8_deser;

    logic       clk;
    logic       rst;
    logic       din;
    logic       din_valid;
    logic       sof;
    logic       auto_en;
    logic [2:0] sel_ext;
    logic       q0, q1, q2, q3, q4, q5, q6, q7;
    logic [2:0] sel_cur;
    logic       busy;
    logic       frame_done;

    int nAsserts = 0;
    int nFail    = 0;
    int doneCount;
    logic [7:0] qv;
    logic [7:0] expQ;

    localparam logic [7:0] FRAME_A = 8'h65;
    localparam logic [7:0] FRAME_B = 8'h8E;

    demux1_8_deser dut (
        .clk        (clk),
        .rst        (rst),
        .din        (din),
        .din_valid  (din_valid),
        .sof        (sof),
        .auto_en    (auto_en),
        .sel_ext    (sel_ext),
        .q0         (q0),
        .q1         (q1),
        .q2         (q2),
        .q3         (q3),
        .q4         (q4),
        .q5         (q5),
        .q6         (q6),
        .q7         (q7),
        .sel_cur    (sel_cur),
        .busy       (busy),
        .frame_done (frame_done)
    );

    // Free-running clock, 10 time units per period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    assign qv = {q7, q6, q5, q4, q3, q2, q1, q0};

    task automatic applyStimulus(input logic v, input logic d, input logic s);
        din_valid = v;
        din       = d;
        sof       = s;
        @(posedge clk);
        #1;
        if (frame_done === 1'b1) doneCount++;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        nAsserts++;
        assert (observed === expected)
        else begin
            nFail++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Sends a full auto-mode frame back to back; bit i of bits is the i-th serial bit.
    task automatic sendFrame(input logic [7:0] bits);
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, bits[i], (i == 0));
        end
        applyStimulus(1'b0, 1'b0, 1'b0);
    endtask

    // Directed test sequence.
    initial begin
        rst = 1'b1; auto_en = 1'b1; sel_ext = 3'd0;
        din = 1'b0; din_valid = 1'b0; sof = 1'b0;
        doneCount = 0;
        applyStimulus(1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b1);
        checkOutput("reset_q", {24'd0, qv}, 32'h00);
        checkOutput("reset_sel", {29'd0, sel_cur}, 32'd0);
        checkOutput("reset_busy", {31'd0, busy}, 32'd0);
        checkOutput("reset_done", {31'd0, frame_done}, 32'd0);
        rst = 1'b0;

        // Plain auto frame 1,0,1,0,0,1,1,0.
        doneCount = 0;
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("idle_ignore_busy", {31'd0, busy}, 32'd0);
        for (int i = 0; i < 7; i++) begin
            applyStimulus(1'b1, FRAME_A[i], (i == 0));
            if (i == 2) begin
                checkOutput("f1_sel_after3", {29'd0, sel_cur}, 32'd3);
                checkOutput("f1_busy", {31'd0, busy}, 32'd1);
            end
        end
        checkOutput("f1_q_before_end", {24'd0, qv}, 32'h00);
        checkOutput("f1_done_before_end", {31'd0, frame_done}, 32'd0);
        applyStimulus(1'b1, FRAME_A[7], 1'b0);
        checkOutput("f1_done", {31'd0, frame_done}, 32'd1);
        checkOutput("f1_q", {24'd0, qv}, 32'h65);
        checkOutput("f1_sel_wrap", {29'd0, sel_cur}, 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("f1_done_drop", {31'd0, frame_done}, 32'd0);
        checkOutput("f1_busy_after", {31'd0, busy}, 32'd0);
        checkOutput("f1_done_count", doneCount, 32'd1);

        // Restart: 5 partial bits, then a fresh frame 0,1,1,1,0,0,0,1.
        doneCount = 0;
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 1'b1, (i == 0));
        end
        checkOutput("rs_sel_partial", {29'd0, sel_cur}, 32'd5);
        applyStimulus(1'b1, FRAME_B[0], 1'b1);
        checkOutput("rs_sel_reload", {29'd0, sel_cur}, 32'd1);
        checkOutput("rs_q_held", {24'd0, qv}, 32'h65);
        for (int i = 1; i < 8; i++) begin
            applyStimulus(1'b1, FRAME_B[i], 1'b0);
        end
        checkOutput("rs_q", {24'd0, qv}, 32'h8E);
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("rs_done_count", doneCount, 32'd1);

        // Gapped frame: 3 bits, 3 idle cycles, 5 bits.
        doneCount = 0;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, FRAME_A[i], (i == 0));
        end
        for (int g = 0; g < 3; g++) begin
            applyStimulus(1'b0, 1'b1, 1'b0);
        end
        checkOutput("gap_sel_hold", {29'd0, sel_cur}, 32'd3);
        checkOutput("gap_busy", {31'd0, busy}, 32'd1);
        checkOutput("gap_q_hold", {24'd0, qv}, 32'h8E);
        for (int i = 3; i < 8; i++) begin
            applyStimulus(1'b1, FRAME_A[i], 1'b0);
        end
        checkOutput("gap_done", {31'd0, frame_done}, 32'd1);
        checkOutput("gap_q", {24'd0, qv}, 32'h65);
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("gap_done_count", doneCount, 32'd1);

        // Abort: auto_en drops after 4 bits.
        doneCount = 0;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, FRAME_B[i], (i == 0));
        end
        auto_en = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("ab_sel", {29'd0, sel_cur}, 32'd0);
        checkOutput("ab_busy", {31'd0, busy}, 32'd0);
        checkOutput("ab_q", {24'd0, qv}, 32'h65);
        checkOutput("ab_done_count", doneCount, 32'd0);

        // Manual mode: 10 writes to random lanes with alternating data.
        expQ = 8'h65;
        for (int k = 0; k < 10; k++) begin
            sel_ext = 3'($urandom_range(0, 7));
            expQ[sel_ext] = k[0];
            applyStimulus(1'b1, k[0], (k % 3 == 0));
            checkOutput("man_q", {24'd0, qv}, {24'd0, expQ});
            checkOutput("man_done", {31'd0, frame_done}, 32'd0);
        end
        checkOutput("man_busy", {31'd0, busy}, 32'd0);

        // Reset mid-frame, then a normal frame.
        auto_en = 1'b1;
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b1, 1'b1, (i == 0));
        end
        rst = 1'b1;
        applyStimulus(1'b1, 1'b1, 1'b0);
        rst = 1'b0;
        checkOutput("rm_q", {24'd0, qv}, 32'h00);
        checkOutput("rm_sel", {29'd0, sel_cur}, 32'd0);
        checkOutput("rm_busy", {31'd0, busy}, 32'd0);
        doneCount = 0;
        sendFrame(FRAME_B);
        checkOutput("rm_frame_q", {24'd0, qv}, 32'h8E);
        checkOutput("rm_done_count", doneCount, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFail);
        $finish;
    end

endmodule
